// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF evaluator: counts edges of a challenge-selected RO pair per response bit.
// Optional RO_PUF_MAJORITY_EN: each bit is the majority of three pair evaluations.
module ro_puf_eval #(
    parameter int NUM_RO = 16,
    parameter int CH_W   = 4,
    parameter int RESP_W = 8,
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 12,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CH_W-1:0]   challenge,
    input  logic [WIN_W-1:0]  win_len,
    input  logic [NUM_RO-1:0] ro_in,
    output logic [NUM_RO-1:0] ro_en,
    output logic              busy,
    output logic              resp_valid,
    output logic [RESP_W-1:0] response
);

    localparam int IW = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int SW = $clog2(SETTLE);
    localparam int TW = (WIN_W > SW) ? WIN_W : SW;
    localparam logic [CH_W-1:0] HALF   = CH_W'(NUM_RO / 2);
    localparam logic [IW-1:0]   LAST   = IW'(RESP_W - 1);
    localparam logic [TW-1:0]   SET_LD = TW'(SETTLE - 1);

    typedef enum logic [2:0] {IDLE, SETUP, COUNT, COMPARE, DONE} state_t;

    state_t            state;
    logic [CH_W-1:0]   chal_q;
    logic [WIN_W-1:0]  win_q;
    logic [WIN_W-1:0]  win_m1;
    logic [IW-1:0]     idx;
    logic [TW-1:0]     tmr;
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic [NUM_RO-1:0] s1, s2, hist, rise;
    logic [CH_W-1:0]   a_sel, b_sel, nxt_base;
    logic              gt;
    logic              bit_done;
    logic              bit_val;

    function automatic logic [NUM_RO-1:0] pair_mask(input logic [CH_W-1:0] base);
        logic [NUM_RO-1:0] m;
        m = '0;
        m[base] = 1'b1;
        m[base + HALF] = 1'b1;
        return m;
    endfunction

    always_ff @(posedge clk) begin
        s1   <= ro_in;
        s2   <= s1;
        hist <= s2;
    end

    assign rise     = s2 & ~hist;
    assign a_sel    = chal_q + CH_W'(idx);
    assign b_sel    = a_sel + HALF;
    assign nxt_base = a_sel + CH_W'(1);
    assign gt       = cnt_a > cnt_b;
    // wraps 0 to all-ones, giving a 2^WIN_W cycle window
    assign win_m1   = win_q - WIN_W'(1);

`ifdef RO_PUF_MAJORITY_EN
    logic [1:0] pass_q;
    logic [1:0] votes;
    logic [1:0] votes_n;

    assign votes_n  = votes + {1'b0, gt};
    assign bit_done = (pass_q == 2'd2);
    assign bit_val  = (votes_n >= 2'd2);

    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            pass_q <= '0;
            votes  <= '0;
        end else if (state == COMPARE) begin
            if (bit_done) begin
                pass_q <= '0;
                votes  <= '0;
            end else begin
                pass_q <= pass_q + 2'd1;
                votes  <= votes_n;
            end
        end
    end
`else
    assign bit_done = 1'b1;
    assign bit_val  = gt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ro_en      <= '0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            response   <= '0;
            idx        <= '0;
            chal_q     <= '0;
            win_q      <= '0;
            tmr        <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        chal_q   <= challenge;
                        win_q    <= win_len;
                        idx      <= '0;
                        response <= '0;
                        ro_en    <= pair_mask(challenge);
                        busy     <= 1'b1;
                        tmr      <= SET_LD;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    cnt_a <= '0;
                    cnt_b <= '0;
                    if (tmr == '0) begin
                        tmr   <= TW'(win_m1);
                        state <= COUNT;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                COUNT: begin
                    if (rise[a_sel] && cnt_a != '1)
                        cnt_a <= cnt_a + CNT_W'(1);
                    if (rise[b_sel] && cnt_b != '1)
                        cnt_b <= cnt_b + CNT_W'(1);
                    if (tmr == '0) begin
                        ro_en <= '0;
                        state <= COMPARE;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                COMPARE: begin
                    if (bit_done)
                        response[idx] <= bit_val;
                    if (bit_done && idx == LAST) begin
                        busy       <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        if (bit_done)
                            idx <= idx + IW'(1);
                        ro_en <= pair_mask(bit_done ? nxt_base : a_sel);
                        tmr   <= SET_LD;
                        state <= SETUP;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
